// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// Optional TX FIFO in front of the shifter, enabled by the macro UART_TX_FIFO_EN.
module uart_tx_frame #(
  parameter int CLK_REF    = 100,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_ref,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic                 o_txd,
  output logic                 o_tx_busy,
  output logic                 o_tx_done,
  output logic [3:0]           o_bit_cnt
`ifdef UART_TX_FIFO_EN
  ,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
`endif
);

  localparam int BIT_CYCLES = CLK_REF * 32'sd1000000 / BAUD_RATE;
  localparam int CW         = (BIT_CYCLES > 32'sd1) ? $clog2(BIT_CYCLES) : 32'sd1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CYCLES - 32'sd1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS);
  localparam logic [3:0]    LAST_IDX  = 4'(DATA_BITS + int'(PARITY != 32'sd0) + STOP_BITS);

  if (DATA_BITS < 32'sd5 || DATA_BITS > 32'sd9 || PARITY < 32'sd0 || PARITY > 32'sd2 ||
      (STOP_BITS != 32'sd1 && STOP_BITS != 32'sd2) || BIT_CYCLES < 32'sd1) begin : g_bad_param
    $error("uart_tx_frame: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] w);
    if (PARITY == 32'sd1) begin
      return ~^w;
    end else begin
      return ^w;
    end
  endfunction

  state_t               state_q;
  logic [CW-1:0]        baud_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 txd_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 ready_q;
  logic                 ready_d;
  logic [3:0]           bit_cnt_q;
  logic                 tick_s;
  logic                 end_s;
  logic                 load_s;
  logic [DATA_BITS-1:0] word_s;

  assign tick_s = (baud_q == BAUD_LAST);
  assign end_s  = (state_q == S_STOP) && tick_s && (bit_cnt_q == LAST_IDX);

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_q;
  logic [AW:0]          rd_ptr_q;
  logic [AW:0]          level_s;
  logic [AW:0]          level_d;
  logic                 push_s;

  assign level_s = wr_ptr_q - rd_ptr_q;
  assign push_s  = i_tx_valid && (level_s != (AW+1)'(FIFO_DEPTH));
  // A frame starts from IDLE, or straight out of the last stop bit, whenever a word is queued.
  assign load_s  = (level_s != {(AW+1){1'b0}}) && ((state_q == S_IDLE) || end_s);
  assign word_s  = mem_q[rd_ptr_q[AW-1:0]];
  assign level_d = level_s + (AW+1)'(push_s) - (AW+1)'(load_s);
  assign ready_d = (level_d != (AW+1)'(FIFO_DEPTH));
  assign o_fifo_level = level_s;

  // FIFO pointers.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (load_s) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  // FIFO storage.
  always_ff @(posedge clk_ref) begin
    if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_tx_data;
    end
  end
`else
  assign load_s = (state_q == S_IDLE) && i_tx_valid && ready_q;
  assign word_s = i_tx_data;

  // Ready drops on acceptance and returns with the end of the frame.
  always_comb begin
    ready_d = ready_q;
    if (load_s) begin
      ready_d = 1'b0;
    end else if (end_s) begin
      ready_d = 1'b1;
    end else begin
      ready_d = ready_q;
    end
  end
`endif

  // Registered ready.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= ready_d;
    end
  end

  // Frame sequencer with registered line, busy, done and bit index.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state_q   <= S_IDLE;
      baud_q    <= {CW{1'b0}};
      shift_q   <= {DATA_BITS{1'b0}};
      par_q     <= 1'b0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bit_cnt_q <= 4'd0;
    end else begin
      done_q <= 1'b0;
      baud_q <= (state_q == S_IDLE || tick_s) ? {CW{1'b0}} : baud_q + CW'(1);
      case (state_q)
        S_IDLE: begin
          bit_cnt_q <= 4'd0;
          if (load_s) begin
            state_q <= S_START;
            shift_q <= word_s;
            par_q   <= parity_bit(word_s);
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            txd_q  <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        S_START: begin
          if (tick_s) begin
            state_q   <= S_DATA;
            txd_q     <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= 4'd1;
          end
        end
        S_DATA: begin
          if (tick_s) begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q != DATA_LAST) begin
              txd_q   <= shift_q[0];
              shift_q <= shift_q >> 1;
            end else if (PARITY != 32'sd0) begin
              state_q <= S_PARITY;
              txd_q   <= par_q;
            end else begin
              state_q <= S_STOP;
              txd_q   <= 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (tick_s) begin
            state_q   <= S_STOP;
            txd_q     <= 1'b1;
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        S_STOP: begin
          if (end_s) begin
            done_q    <= 1'b1;
            bit_cnt_q <= 4'd0;
            if (load_s) begin
              state_q <= S_START;
              shift_q <= word_s;
              par_q   <= parity_bit(word_s);
              txd_q   <= 1'b0;
              busy_q  <= 1'b1;
            end else begin
              state_q <= S_IDLE;
              txd_q   <= 1'b1;
              busy_q  <= 1'b0;
            end
          end else if (tick_s) begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          txd_q     <= 1'b1;
          busy_q    <= 1'b0;
          bit_cnt_q <= 4'd0;
        end
      endcase
    end
  end

  assign o_tx_ready = ready_q;
  assign o_txd      = txd_q;
  assign o_tx_busy  = busy_q;
  assign o_tx_done  = done_q;
  assign o_bit_cnt  = bit_cnt_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three instances (8N1, 7E2, 7O2) at 4 clocks per bit,
// checked against a frame-level bit-list reference model.
module tb_uart_tx_frame;

  logic       clk_ref = 1'b0;
  logic       rst;
  logic [2:0] tx_valid;
  logic [8:0] tx_data [3];
  logic [2:0] txd_s, busy_s, ready_s, done_s;
  logic [3:0] cnt_s [3];
`ifdef UART_TX_FIFO_EN
  logic [2:0] lvl_s [3];
`endif

  int checks = 0;
  int errors = 0;

  int cfg_db  [3] = '{8, 7, 7};
  int cfg_par [3] = '{0, 2, 1};
  int cfg_sb  [3] = '{1, 2, 2};
  logic exp_bits [16];

  always #5 clk_ref = ~clk_ref;

  uart_tx_frame #(.CLK_REF(1), .BAUD_RATE(250000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk_ref(clk_ref), .rst(rst), .i_tx_data(tx_data[0][7:0]), .i_tx_valid(tx_valid[0]),
    .o_tx_ready(ready_s[0]), .o_txd(txd_s[0]), .o_tx_busy(busy_s[0]), .o_tx_done(done_s[0]),
`ifdef UART_TX_FIFO_EN
    .o_fifo_level(lvl_s[0]),
`endif
    .o_bit_cnt(cnt_s[0]));

  uart_tx_frame #(.CLK_REF(1), .BAUD_RATE(250000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut1 (
    .clk_ref(clk_ref), .rst(rst), .i_tx_data(tx_data[1][6:0]), .i_tx_valid(tx_valid[1]),
    .o_tx_ready(ready_s[1]), .o_txd(txd_s[1]), .o_tx_busy(busy_s[1]), .o_tx_done(done_s[1]),
`ifdef UART_TX_FIFO_EN
    .o_fifo_level(lvl_s[1]),
`endif
    .o_bit_cnt(cnt_s[1]));

  uart_tx_frame #(.CLK_REF(1), .BAUD_RATE(250000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_dut2 (
    .clk_ref(clk_ref), .rst(rst), .i_tx_data(tx_data[2][6:0]), .i_tx_valid(tx_valid[2]),
    .o_tx_ready(ready_s[2]), .o_txd(txd_s[2]), .o_tx_busy(busy_s[2]), .o_tx_done(done_s[2]),
`ifdef UART_TX_FIFO_EN
    .o_fifo_level(lvl_s[2]),
`endif
    .o_bit_cnt(cnt_s[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line levels of one frame, one entry per bit period; returns the bit count.
  function automatic int build_frame(input int k, input logic [8:0] w);
    int n = 0;
    int ones = 0;
    exp_bits[n] = 1'b0; n = n + 1;
    for (int i = 0; i < cfg_db[k]; i++) begin
      exp_bits[n] = w[i]; n = n + 1;
      ones = ones + int'(w[i]);
    end
    if (cfg_par[k] == 1) begin
      exp_bits[n] = (ones % 2 == 0); n = n + 1;
    end else if (cfg_par[k] == 2) begin
      exp_bits[n] = (ones % 2 == 1); n = n + 1;
    end
    for (int i = 0; i < cfg_sb[k]; i++) begin
      exp_bits[n] = 1'b1; n = n + 1;
    end
    return n;
  endfunction

  task automatic check_idle(input int k, input string tag);
    check({tag, "_txd"},   32'(txd_s[k]),   32'd1);
    check({tag, "_busy"},  32'(busy_s[k]),  32'd0);
    check({tag, "_ready"}, 32'(ready_s[k]), 32'd1);
    check({tag, "_done"},  32'(done_s[k]),  32'd0);
    check({tag, "_cnt"},   32'(cnt_s[k]),   32'd0);
  endtask

  // Called right after the accepting edge; ends on the negedge where done is expected.
  task automatic check_frame(input int k, input logic [8:0] w, input logic kv, input logic [8:0] kd);
    int n;
    n = build_frame(k, w);
    for (int t = 0; t < n * 4; t++) begin
      @(negedge clk_ref);
      if (t == 0) begin
        tx_valid[k] = kv;
        tx_data[k]  = kd;
      end
      check($sformatf("k%0d_w%0h_txd_t%0d", k, w, t), 32'(txd_s[k]), 32'(exp_bits[t / 4]));
      check($sformatf("k%0d_w%0h_cnt_t%0d", k, w, t), 32'(cnt_s[k]), 32'(t / 4));
      check($sformatf("k%0d_busy_t%0d", k, t), 32'(busy_s[k]), 32'd1);
      check($sformatf("k%0d_ready_t%0d", k, t), 32'(ready_s[k]), 32'd0);
      check($sformatf("k%0d_done_t%0d", k, t), 32'(done_s[k]), 32'd0);
    end
    @(negedge clk_ref);
    check($sformatf("k%0d_end_done", k), 32'(done_s[k]), 32'd1);
    check($sformatf("k%0d_end_busy", k), 32'(busy_s[k]), 32'd0);
    check($sformatf("k%0d_end_ready", k), 32'(ready_s[k]), 32'd1);
    check($sformatf("k%0d_end_txd", k), 32'(txd_s[k]), 32'd1);
    check($sformatf("k%0d_end_cnt", k), 32'(cnt_s[k]), 32'd0);
  endtask

  task automatic send_frame(input int k, input logic [8:0] w);
    @(negedge clk_ref);
    tx_valid[k] = 1'b1;
    tx_data[k]  = w;
    @(posedge clk_ref);
    check_frame(k, w, 1'b0, 9'($urandom));
    @(negedge clk_ref);
    check_idle(k, $sformatf("k%0d_after", k));
  endtask

  initial begin
    rst      = 1'b1;
    tx_valid = 3'b000;
    for (int k = 0; k < 3; k++) tx_data[k] = 9'h000;
    repeat (3) @(posedge clk_ref);
    @(negedge clk_ref);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) check_idle(k, $sformatf("rst_k%0d", k));

`ifdef UART_TX_FIFO_EN
    begin : fifo_test
      logic [8:0] q [$];
      logic [8:0] words [6];
      logic [8:0] cur;
      logic       wr, pop, done_e, fend;
      bit         idle = 1'b1;
      int         rem = 0;
      int         flen = 0;
      int         idx;
      for (int i = 0; i < 6; i++) words[i] = 9'($urandom_range(0, 255));
      cur = 9'h000;
      for (int cyc = 0; cyc < 240; cyc++) begin
        tx_valid[0] = (cyc < 6);
        tx_data[0]  = (cyc < 6) ? words[cyc] : 9'($urandom_range(0, 255));
        @(posedge clk_ref);
        wr     = tx_valid[0] && (q.size() < 4);
        fend   = !idle && (rem == 1);
        pop    = (idle || fend) && (q.size() > 0);
        done_e = fend;
        if (!idle) rem = rem - 1;
        if (fend) idle = 1'b1;
        if (pop) begin
          cur  = q.pop_front();
          flen = build_frame(0, cur) * 4;
          rem  = flen;
          idle = 1'b0;
        end
        if (wr) q.push_back(tx_data[0]);
        @(negedge clk_ref);
        idx = idle ? 0 : (flen - rem) / 4;
        check($sformatf("fifo_lvl_c%0d", cyc), 32'(lvl_s[0]), 32'(q.size()));
        check($sformatf("fifo_ready_c%0d", cyc), 32'(ready_s[0]), 32'(q.size() < 4));
        check($sformatf("fifo_done_c%0d", cyc), 32'(done_s[0]), 32'(done_e));
        check($sformatf("fifo_busy_c%0d", cyc), 32'(busy_s[0]), 32'(!idle));
        check($sformatf("fifo_txd_c%0d", cyc), 32'(txd_s[0]), idle ? 32'd1 : 32'(exp_bits[idx]));
        check($sformatf("fifo_cnt_c%0d", cyc), 32'(cnt_s[0]), 32'(idx));
      end
      tx_valid[0] = 1'b0;
    end
`else
    // Directed frames from the test plan.
    send_frame(0, 9'h0A5);
    send_frame(1, 9'h055);
    send_frame(2, 9'h055);

    // Valid held across two words: one idle clock, second word captured only after ready.
    @(negedge clk_ref);
    tx_valid[0] = 1'b1;
    tx_data[0]  = 9'h001;
    @(posedge clk_ref);
    check_frame(0, 9'h001, 1'b1, 9'h080);
    @(posedge clk_ref);
    check_frame(0, 9'h080, 1'b0, 9'h0FF);
    @(negedge clk_ref);
    check_idle(0, "b2b_after");

    // Reset during data bit 3 aborts the frame without a done pulse.
    @(negedge clk_ref);
    tx_valid[0] = 1'b1;
    tx_data[0]  = 9'h0C3;
    @(posedge clk_ref);
    for (int t = 0; t <= 13; t++) begin
      @(negedge clk_ref);
      if (t == 0) tx_valid[0] = 1'b0;
    end
    check("abort_pre_cnt", 32'(cnt_s[0]), 32'd3);
    rst = 1'b1;
    @(negedge clk_ref);
    rst = 1'b0;
    check_idle(0, "abort");
    for (int t = 0; t < 40; t++) begin
      @(negedge clk_ref);
      check($sformatf("abort_nodone_t%0d", t), 32'(done_s[0]), 32'd0);
      check($sformatf("abort_line_t%0d", t), 32'(txd_s[0]), 32'd1);
    end
    send_frame(0, 9'h03C);

    // Random words across all three configurations.
    for (int r = 0; r < 9; r++) begin
      send_frame(r % 3, 9'($urandom_range(0, 511)));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
